// File: rtl/uart_pkg.sv
// Shared types and defaults for the host-side UART command initiator.
package uart_pkg;

  localparam int CMD_ADDR_WIDTH     = 7;
  localparam int CMD_TIMEOUT_CYCLES = 100000;
  localparam int CMD_MAX_RETRIES    = 2;

  typedef logic [6:0] reg_rwaddr;

  localparam logic CMD_RW_WRITE = 1'b1;
  localparam logic CMD_RW_READ  = 1'b0;

  typedef struct packed {
    logic      rw;
    logic [6:0] addr;
  } cmd_byte_t;

  typedef enum logic [2:0] {
    CI_IDLE,
    CI_TX_CMD,
    CI_TX_CMD_WAIT,
    CI_TX_DAT,
    CI_TX_DAT_WAIT,
    CI_WAIT_RESP,
    CI_DONE
  } cmd_init_state_t;

  // Command byte as it goes on the wire: rw flag in the MSB, address below.
  function automatic logic [7:0] make_cmd_byte(input logic rw, input reg_rwaddr addr);
    cmd_byte_t cmd;
    cmd.rw   = rw;
    cmd.addr = addr;
    return cmd;
  endfunction

endpackage

// File: rtl/uart_cmd_initiator_if.sv
// Request/response handshake between local logic and the command initiator.
// master = requesting logic, slave = uart_cmd_initiator.
interface uart_cmd_initiator_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_wdata;
  logic                  resp_valid;
  logic [7:0]            resp_rdata;
  logic                  resp_timeout;
  logic                  resp_rx_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_timeout, resp_rx_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_timeout, resp_rx_err
  );
endinterface

// File: rtl/uart_cmd_initiator_timeout_ctr.sv
// Response timeout counter: cleared while idle, counts while enabled and
// flags the terminal count TIMEOUT_CYCLES-1.
module cmd_timeout_ctr
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = CMD_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Count up from zero while enabled; saturate at the terminal value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign terminal = enable && (count == LAST);

endmodule

// File: rtl/uart_cmd_initiator.sv
// Host-side UART command initiator: turns register read/write requests into
// command/data bytes on the UART tx byte interface and collects the single
// read response byte from the UART rx byte interface.
// Optional build macro: CMD_INIT_RETRY_EN (re-issue timed-out reads).
module uart_cmd_initiator
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH     = CMD_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = CMD_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = CMD_MAX_RETRIES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  uart_cmd_initiator_if.slave    req,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_data_valid,
  input  logic                   i_tx_busy,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_data_valid,
  input  logic                   i_rx_error,
  output logic                   o_unsolicited
);

  cmd_init_state_t       state;
  cmd_init_state_t       next_state;

  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;
  logic [7:0]            cmd_byte;
  logic                  wait_first;
  logic                  accept;

  logic                  timeout_hit;
  logic                  retry_ok;

  logic                  load_result;
  logic [7:0]            result_rdata;
  logic                  result_timeout;
  logic                  result_rx_err;

  logic [7:0]            rdata_q;
  logic                  timeout_q;
  logic                  rx_err_q;
  logic                  unsolicited_q;

  assign accept   = (state == CI_IDLE) && req.req_valid;
  assign cmd_byte = make_cmd_byte(rw_q, reg_rwaddr'(addr_q));

  cmd_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (state != CI_WAIT_RESP),
    .enable  (state == CI_WAIT_RESP),
    .terminal(timeout_hit)
  );

`ifdef CMD_INIT_RETRY_EN
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic [RETRY_W-1:0] retry_cnt;
  logic               retry;

  assign retry_ok = (retry_cnt < RETRY_W'(MAX_RETRIES));
  assign retry    = (state == CI_WAIT_RESP) && !i_rx_error && !i_rx_data_valid
                    && timeout_hit && retry_ok;

  // Attempts made for the current read; restarted with every new request.
  always_ff @(posedge i_clk) begin
    if (i_rst || accept) begin
      retry_cnt <= '0;
    end else if (retry) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end
`else
  // Without the retry option every timeout is final.
  assign retry_ok = 1'b0 && (MAX_RETRIES > 0);
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= CI_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; also decides the completion status loaded on DONE entry.
  always_comb begin
    next_state     = state;
    load_result    = 1'b0;
    result_rdata   = 8'h00;
    result_timeout = 1'b0;
    result_rx_err  = 1'b0;
    case (state)
      CI_IDLE: begin
        if (req.req_valid) next_state = CI_TX_CMD;
      end
      CI_TX_CMD: begin
        if (!i_tx_busy) next_state = CI_TX_CMD_WAIT;
      end
      CI_TX_CMD_WAIT: begin
        if (!wait_first && !i_tx_busy) begin
          next_state = (rw_q == CMD_RW_WRITE) ? CI_TX_DAT : CI_WAIT_RESP;
        end
      end
      CI_TX_DAT: begin
        if (!i_tx_busy) next_state = CI_TX_DAT_WAIT;
      end
      CI_TX_DAT_WAIT: begin
        if (!wait_first && !i_tx_busy) begin
          next_state  = CI_DONE;
          load_result = 1'b1;
        end
      end
      CI_WAIT_RESP: begin
        if (i_rx_error) begin
          next_state    = CI_DONE;
          load_result   = 1'b1;
          result_rx_err = 1'b1;
        end else if (i_rx_data_valid) begin
          next_state   = CI_DONE;
          load_result  = 1'b1;
          result_rdata = i_rx_data;
        end else if (timeout_hit) begin
          if (retry_ok) begin
            next_state = CI_TX_CMD;
          end else begin
            next_state     = CI_DONE;
            load_result    = 1'b1;
            result_timeout = 1'b1;
          end
        end
      end
      CI_DONE: begin
        next_state = CI_IDLE;
      end
      default: begin
        next_state = CI_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req.req_ready   = (state == CI_IDLE);
    req.resp_valid  = (state == CI_DONE);
    o_tx_data_valid = ((state == CI_TX_CMD) || (state == CI_TX_DAT)) && !i_tx_busy;
    o_tx_data       = 8'h00;
    if (state == CI_TX_CMD) begin
      o_tx_data = cmd_byte;
    end else if (state == CI_TX_DAT) begin
      o_tx_data = wdata_q;
    end
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rw_q    <= CMD_RW_READ;
      addr_q  <= '0;
      wdata_q <= 8'h00;
    end else if (accept) begin
      rw_q    <= req.req_write;
      addr_q  <= req.req_addr;
      wdata_q <= req.req_wdata;
    end
  end

  // Marks the first cycle after a strobe, when tx busy may not have risen yet.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_first <= 1'b0;
    end else begin
      wait_first <= o_tx_data_valid;
    end
  end

  // Completion status, held until the next completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q   <= 8'h00;
      timeout_q <= 1'b0;
      rx_err_q  <= 1'b0;
    end else if (load_result) begin
      rdata_q   <= result_rdata;
      timeout_q <= result_timeout;
      rx_err_q  <= result_rx_err;
    end
  end

  // Sticky flag for rx activity that no read is waiting for.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      unsolicited_q <= 1'b0;
    end else if ((i_rx_data_valid || i_rx_error) && (state != CI_WAIT_RESP)) begin
      unsolicited_q <= 1'b1;
    end
  end

  assign req.resp_rdata   = rdata_q;
  assign req.resp_timeout = timeout_q;
  assign req.resp_rx_err  = rx_err_q;
  assign o_unsolicited    = unsolicited_q;

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Testbench for uart_cmd_initiator: scoreboard of expected tx bytes and
// responses, a busy-for-N-cycles UART tx model and a delayed rx responder.
`timescale 1ns/1ps
module tb_uart_cmd_initiator;

  localparam int TIMEOUT     = 20;
  localparam int MAX_RETRIES = 2;
  localparam int BUSY_CYCLES = 10;
`ifdef CMD_INIT_RETRY_EN
  localparam int ATTEMPTS = MAX_RETRIES + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  typedef struct packed {
    logic [7:0] rdata;
    logic       timeout;
    logic       rx_err;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       busy_model = 1'b0;
  logic       busy_force = 1'b0;
  logic       tx_busy;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic       unsolicited;

  assign tx_busy = busy_model | busy_force;

  uart_cmd_initiator_if #(.ADDR_WIDTH(7)) bus ();

  uart_cmd_initiator #(
    .ADDR_WIDTH    (7),
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .req            (bus),
    .o_tx_data      (tx_data),
    .o_tx_data_valid(tx_data_valid),
    .i_tx_busy      (tx_busy),
    .i_rx_data      (rx_data),
    .i_rx_data_valid(rx_data_valid),
    .i_rx_error     (rx_error),
    .o_unsolicited  (unsolicited)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0] tx_q[$];
  resp_t      resp_q[$];
  int         strobe_count = 0;
  int         last_strobe_cyc = 0;
  int         resp_seen_count = 0;

  int         rsp_mode = 0;
  int         rsp_delay = 0;
  logic [7:0] rsp_byte = 8'h00;
  int         rsp_guard;

  int         rc, s0, r0, extra;
  bit         flag;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic resp_t mkResp(input logic [7:0] rdata, input logic to, input logic err);
    resp_t r;
    r.rdata   = rdata;
    r.timeout = to;
    r.rx_err  = err;
    return r;
  endfunction

  // UART tx model: busy for BUSY_CYCLES cycles after each accepted strobe.
  initial forever begin
    @(negedge clk);
    if (tx_data_valid) begin
      @(posedge clk); #1 busy_model = 1'b1;
      repeat (BUSY_CYCLES) @(posedge clk);
      #1 busy_model = 1'b0;
    end
  end

  // Responder: after a read command finishes shifting, wait rsp_delay cycles
  // and strobe the rx byte (mode 1) or byte plus framing error (mode 2).
  initial forever begin
    @(negedge clk);
    if (tx_data_valid && (rsp_mode != 0)) begin
      rsp_guard = 0;
      @(posedge clk); #2;
      while (tx_busy && (rsp_guard < 1000)) begin
        @(posedge clk); #2;
        rsp_guard++;
      end
      repeat (rsp_delay) @(posedge clk);
      #1;
      rx_data       = rsp_byte;
      rx_data_valid = 1'b1;
      rx_error      = (rsp_mode == 2);
      @(posedge clk); #1;
      rx_data_valid = 1'b0;
      rx_error      = 1'b0;
      rx_data       = 8'h00;
      rsp_mode      = 0;
    end
  end

  // Scoreboard monitor: every strobe and completion is matched against the queues.
  initial forever begin
    resp_t exp;
    @(negedge clk);
    if (tx_data_valid) begin
      strobe_count++;
      last_strobe_cyc = cyc;
      checkOutput("tx_idle_at_strobe", 32'(tx_busy), 32'd0);
      if (tx_q.size() == 0) checkOutput("tx_unexpected_byte", 32'(tx_data), 32'h100);
      else checkOutput("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
    end
    if (bus.resp_valid) begin
      resp_seen_count++;
      if (resp_q.size() == 0) begin
        checkOutput("resp_unexpected", 32'(bus.resp_rdata), 32'h100);
      end else begin
        exp = resp_q.pop_front();
        checkOutput("resp_rdata", 32'(bus.resp_rdata), 32'(exp.rdata));
        checkOutput("resp_timeout", 32'(bus.resp_timeout), 32'(exp.timeout));
        checkOutput("resp_rx_err", 32'(bus.resp_rx_err), 32'(exp.rx_err));
      end
    end
  end

  task automatic issueRequest(input logic write, input logic [6:0] addr, input logic [7:0] wdata);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk);
      if (bus.req_ready) accepted = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("req_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic waitResp(input string tag, output int resp_cyc);
    bit seen;
    seen = 1'b0;
    resp_cyc = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        seen = 1'b1;
        resp_cyc = cyc;
      end
    end
    checkOutput({tag, "_resp_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_resp_one_cycle"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({tag, "_ready_after_done"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic write, input logic [6:0] addr,
                               input logic [7:0] wdata, input int n_cmd, input resp_t exp,
                               output int resp_cyc);
    for (int i = 0; i < n_cmd; i++) tx_q.push_back({write, addr});
    if (write) tx_q.push_back(wdata);
    resp_q.push_back(exp);
    issueRequest(write, addr, wdata);
    waitResp(tag, resp_cyc);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 7'h00;
    bus.req_wdata = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_data_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_rdata", 32'(bus.resp_rdata), 32'd0);
    checkOutput("rst_timeout", 32'(bus.resp_timeout), 32'd0);
    checkOutput("rst_rx_err", 32'(bus.resp_rx_err), 32'd0);
    checkOutput("rst_unsolicited", 32'(unsolicited), 32'd0);

    $display("[TB] write 0x05 <- 0xA7");
    applyStimulus("wr05", 1'b1, 7'h05, 8'hA7, 1, mkResp(8'h00, 1'b0, 1'b0), rc);

    $display("[TB] read 0x02, response 0x3C");
    rsp_mode = 1; rsp_delay = 12; rsp_byte = 8'h3C;
    applyStimulus("rd02", 1'b0, 7'h02, 8'h00, 1, mkResp(8'h3C, 1'b0, 1'b0), rc);

    $display("[TB] read 0x03, response on the terminal-count cycle");
    rsp_mode = 1; rsp_delay = TIMEOUT; rsp_byte = 8'h96;
    applyStimulus("rd03_edge", 1'b0, 7'h03, 8'h00, 1, mkResp(8'h96, 1'b0, 1'b0), rc);

    $display("[TB] read 0x07, no response");
    rsp_mode = 0;
    s0 = strobe_count;
    applyStimulus("rd07_to", 1'b0, 7'h07, 8'h00, ATTEMPTS, mkResp(8'h00, 1'b1, 1'b0), rc);
    checkOutput("to_cmd_attempts", 32'(strobe_count - s0), 32'(ATTEMPTS));
    checkOutput("to_latency", 32'(rc - last_strobe_cyc), 32'(BUSY_CYCLES + 2 + TIMEOUT));

    $display("[TB] read 0x04, rx error and data together");
    rsp_mode = 2; rsp_delay = 5; rsp_byte = 8'h5A;
    applyStimulus("rd04_err", 1'b0, 7'h04, 8'h00, 1, mkResp(8'h00, 1'b0, 1'b1), rc);
    checkOutput("hold_rx_err", 32'(bus.resp_rx_err), 32'd1);
    checkOutput("hold_rdata", 32'(bus.resp_rdata), 32'd0);

    $display("[TB] rx byte while idle");
    checkOutput("unsol_before", 32'(unsolicited), 32'd0);
    @(posedge clk); #1;
    rx_data = 8'hEE; rx_data_valid = 1'b1;
    @(posedge clk); #1;
    rx_data = 8'h00; rx_data_valid = 1'b0;
    @(negedge clk);
    checkOutput("unsol_set", 32'(unsolicited), 32'd1);

    $display("[TB] back-to-back writes, tx busy at accept");
    tx_q.push_back(8'h90); tx_q.push_back(8'h55);
    tx_q.push_back(8'h91); tx_q.push_back(8'h66);
    resp_q.push_back(mkResp(8'h00, 1'b0, 1'b0));
    resp_q.push_back(mkResp(8'h00, 1'b0, 1'b0));
    s0 = strobe_count;
    r0 = resp_seen_count;
    @(posedge clk); #1;
    busy_force = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'h10; bus.req_wdata = 8'h55;
    flag = 1'b0;
    for (int i = 0; i < 50 && !flag; i++) begin
      @(negedge clk);
      if (bus.req_ready) flag = 1'b1;
    end
    checkOutput("b2b_first_accept", 32'(flag), 32'd1);
    @(posedge clk); #1;
    bus.req_addr = 7'h11; bus.req_wdata = 8'h66;
    repeat (5) @(posedge clk);
    checkOutput("b2b_no_strobe_while_busy", 32'(strobe_count - s0), 32'd0);
    #1 busy_force = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 300 && !flag; i++) begin
      @(negedge clk);
      if (bus.req_ready) flag = 1'b1;
    end
    checkOutput("b2b_second_ready", 32'(flag), 32'd1);
    checkOutput("b2b_first_done_before_second", 32'(resp_seen_count - r0), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    waitResp("b2b_second", rc);
    checkOutput("b2b_strobes", 32'(strobe_count - s0), 32'd4);
    checkOutput("unsol_sticky", 32'(unsolicited), 32'd1);

    $display("[TB] reset during data byte wait");
    tx_q.push_back(8'hA0); tx_q.push_back(8'h33);
    s0 = strobe_count;
    r0 = resp_seen_count;
    issueRequest(1'b1, 7'h20, 8'h33);
    flag = 1'b0;
    for (int i = 0; i < 200 && !flag; i++) begin
      @(negedge clk);
      if (strobe_count >= s0 + 2) flag = 1'b1;
    end
    checkOutput("rst_data_byte_sent", 32'(flag), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("midrst_unsol_cleared", 32'(unsolicited), 32'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.resp_valid) extra++;
    end
    checkOutput("midrst_no_resp", 32'(extra), 32'd0);

    $display("[TB] read 0x0A after reset");
    rsp_mode = 1; rsp_delay = 12; rsp_byte = 8'hC3;
    applyStimulus("rd0a", 1'b0, 7'h0A, 8'h00, 1, mkResp(8'hC3, 1'b0, 1'b0), rc);

    checkOutput("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
